// File: rtl/sargantana_icache_refill_unit.sv
// sargantana_icache_refill_unit
// Refill controller between the icache control FSM and the IFILL port.
// Accepts one line miss, issues a line-aligned fill request, assembles the
// response beats into a full line and hands it over with its victim way.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no refill in flight, a new miss can be accepted
// S_REQ       | fill request presented to memory side, waiting for ack
// S_WAIT_DATA | request acked, collecting response beats into the line
// S_DONE      | line assembled, line_valid_o pulses unless killed now
//
// The killed flag travels with the request: once set (kill, beat order
// error) the refill still drains its beats but never delivers a line.

module sargantana_icache_refill_unit #(
    parameter int unsigned LINE_WIDTH   = 256,
    parameter int unsigned BEAT_WIDTH   = 64,
    parameter int unsigned PADDR_SIZE   = 40,
    parameter int unsigned N_WAY        = 4,
    parameter int unsigned OFFSET_WIDTH = 5,
    localparam int unsigned NBEATS      = LINE_WIDTH / BEAT_WIDTH,
    localparam int unsigned WAY_W       = (N_WAY > 1) ? $clog2(N_WAY) : 1,
    localparam int unsigned BEAT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,

    input  logic                  miss_valid_i,
    input  logic [PADDR_SIZE-1:0] miss_paddr_i,
    input  logic [WAY_W-1:0]      miss_way_i,
    input  logic                  kill_i,
    output logic                  ready_o,
    output logic                  busy_o,

    output logic                  ifill_req_valid_o,
    output logic [PADDR_SIZE-1:0] ifill_req_paddr_o,
    output logic [WAY_W-1:0]      ifill_req_way_o,
    input  logic                  ifill_ack_i,
    input  logic                  ifill_resp_valid_i,
    input  logic [BEAT_W-1:0]     ifill_resp_beat_i,
    input  logic [BEAT_WIDTH-1:0] ifill_resp_data_i,

    output logic                  line_valid_o,
    output logic [LINE_WIDTH-1:0] line_data_o,
    output logic [PADDR_SIZE-1:0] line_paddr_o,
    output logic [WAY_W-1:0]      line_way_o,
    output logic                  beat_err_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    state_t                state_q,  state_d;
    logic                  killed_q, killed_d;
    logic [BEAT_W-1:0]     cnt_q,    cnt_d;
    logic [PADDR_SIZE-1:0] paddr_q,  paddr_d;
    logic [WAY_W-1:0]      way_q,    way_d;
    logic [LINE_WIDTH-1:0] line_q,   line_d;
    logic                  beat_err;
    logic                  beat_mismatch;

    // Next-state, request latch and beat assembly; stray beats outside
    // WAIT_DATA are dropped and only flagged.
    always_comb begin
        state_d       = state_q;
        killed_d      = killed_q;
        cnt_d         = cnt_q;
        paddr_d       = paddr_q;
        way_d         = way_q;
        line_d        = line_q;
        beat_err      = 1'b0;
        beat_mismatch = 1'b0;

        case (state_q)
            S_IDLE: begin
                beat_err = ifill_resp_valid_i;
                if (miss_valid_i && !kill_i) begin
                    paddr_d                    = miss_paddr_i;
                    paddr_d[OFFSET_WIDTH-1:0]  = '0;
                    way_d                      = miss_way_i;
                    cnt_d                      = '0;
                    killed_d                   = 1'b0;
                    state_d                    = S_REQ;
                end
            end

            S_REQ: begin
                beat_err = ifill_resp_valid_i;
                // A request cannot be retracted, so kill only marks it.
                if (kill_i) begin
                    killed_d = 1'b1;
                end
                if (ifill_ack_i) begin
                    state_d = S_WAIT_DATA;
                end
            end

            S_WAIT_DATA: begin
                if (kill_i) begin
                    killed_d = 1'b1;
                end
                if (ifill_resp_valid_i) begin
                    beat_mismatch = (ifill_resp_beat_i != cnt_q);
                    if (beat_mismatch) begin
                        beat_err = 1'b1;
                        killed_d = 1'b1;
                    end
                    // Beats land in arrival order regardless of their index.
                    for (int i = 0; i < NBEATS; i++) begin
                        if (cnt_q == BEAT_W'(i)) begin
                            line_d[i*BEAT_WIDTH +: BEAT_WIDTH] = ifill_resp_data_i;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        if (killed_q || kill_i || beat_mismatch) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end

            S_DONE: begin
                beat_err = ifill_resp_valid_i;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            killed_q <= 1'b0;
            cnt_q    <= '0;
            paddr_q  <= '0;
            way_q    <= '0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            killed_q <= killed_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            way_q    <= way_d;
            line_q   <= line_d;
        end
    end

    assign ready_o           = (state_q == S_IDLE);
    assign busy_o            = (state_q != S_IDLE);
    assign ifill_req_valid_o = (state_q == S_REQ);
    assign ifill_req_paddr_o = paddr_q;
    assign ifill_req_way_o   = way_q;
    // A kill arriving in DONE still suppresses the array write.
    assign line_valid_o      = (state_q == S_DONE) && !kill_i;
    assign line_data_o       = line_q;
    assign line_paddr_o      = paddr_q;
    assign line_way_o        = way_q;
    assign beat_err_o        = beat_err;

endmodule

// File: tb/tb_sargantana_icache_refill_unit.sv
// Directed bench for sargantana_icache_refill_unit: default 4-beat instance
// plus a single-beat instance (BEAT_WIDTH = LINE_WIDTH).

module tb_sargantana_icache_refill_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    // Instance A: defaults, NBEATS = 4
    logic          miss_valid, kill, ack, resp_valid;
    logic [39:0]   miss_paddr;
    logic [1:0]    miss_way;
    logic [1:0]    resp_beat;
    logic [63:0]   resp_data;
    logic          ready, busy, req_valid, line_valid, beat_err;
    logic [39:0]   req_paddr, line_paddr;
    logic [1:0]    req_way, line_way;
    logic [255:0]  line_data;

    // Instance B: NBEATS = 1
    logic          miss_valid_b, kill_b, ack_b, resp_valid_b;
    logic [39:0]   miss_paddr_b;
    logic [1:0]    miss_way_b;
    logic [0:0]    resp_beat_b;
    logic [255:0]  resp_data_b;
    logic          ready_b, busy_b, req_valid_b, line_valid_b, beat_err_b;
    logic [39:0]   req_paddr_b, line_paddr_b;
    logic [1:0]    req_way_b, line_way_b;
    logic [255:0]  line_data_b;

    int n_vec = 0;
    int n_err = 0;

    sargantana_icache_refill_unit dut_a (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .miss_valid_i       (miss_valid),
        .miss_paddr_i       (miss_paddr),
        .miss_way_i         (miss_way),
        .kill_i             (kill),
        .ready_o            (ready),
        .busy_o             (busy),
        .ifill_req_valid_o  (req_valid),
        .ifill_req_paddr_o  (req_paddr),
        .ifill_req_way_o    (req_way),
        .ifill_ack_i        (ack),
        .ifill_resp_valid_i (resp_valid),
        .ifill_resp_beat_i  (resp_beat),
        .ifill_resp_data_i  (resp_data),
        .line_valid_o       (line_valid),
        .line_data_o        (line_data),
        .line_paddr_o       (line_paddr),
        .line_way_o         (line_way),
        .beat_err_o         (beat_err)
    );

    sargantana_icache_refill_unit #(
        .LINE_WIDTH (256),
        .BEAT_WIDTH (256)
    ) dut_b (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .miss_valid_i       (miss_valid_b),
        .miss_paddr_i       (miss_paddr_b),
        .miss_way_i         (miss_way_b),
        .kill_i             (kill_b),
        .ready_o            (ready_b),
        .busy_o             (busy_b),
        .ifill_req_valid_o  (req_valid_b),
        .ifill_req_paddr_o  (req_paddr_b),
        .ifill_req_way_o    (req_way_b),
        .ifill_ack_i        (ack_b),
        .ifill_resp_valid_i (resp_valid_b),
        .ifill_resp_beat_i  (resp_beat_b),
        .ifill_resp_data_i  (resp_data_b),
        .line_valid_o       (line_valid_b),
        .line_data_o        (line_data_b),
        .line_paddr_o       (line_paddr_b),
        .line_way_o         (line_way_b),
        .beat_err_o         (beat_err_b)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a miss for one cycle; returns in the cycle after acceptance.
    task automatic issue_miss(input logic [39:0] pa, input logic [1:0] w);
        miss_valid = 1'b1;
        miss_paddr = pa;
        miss_way   = w;
        #1 check("ready_at_miss", ready, 1'b1);
        tick();
        miss_valid = 1'b0;
        miss_paddr = '0;
        miss_way   = '0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        #1 check("req_valid_at_ack", req_valid, 1'b1);
        tick();
        ack = 1'b0;
    endtask

    task automatic send_beat(input logic [1:0] idx, input logic [63:0] d, input logic exp_err, input string tag);
        resp_valid = 1'b1;
        resp_beat  = idx;
        resp_data  = d;
        #1 check(tag, beat_err, exp_err);
        tick();
        resp_valid = 1'b0;
        resp_beat  = '0;
        resp_data  = '0;
    endtask

    localparam logic [255:0] LINE_ABCD =
        256'h000000000000000D_000000000000000C_000000000000000B_000000000000000A;
    localparam logic [255:0] LINE_MIN =
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    localparam logic [255:0] LINE_ONE =
        256'hDEADBEEF_01234567_89ABCDEF_FEDCBA98_76543210_CAFEF00D_0BADC0DE_5A5AA5A5;

    initial begin
        rstn = 1'b0;
        miss_valid = 0; miss_paddr = '0; miss_way = '0; kill = 0; ack = 0;
        resp_valid = 0; resp_beat = '0; resp_data = '0;
        miss_valid_b = 0; miss_paddr_b = '0; miss_way_b = '0; kill_b = 0; ack_b = 0;
        resp_valid_b = 0; resp_beat_b = '0; resp_data_b = '0;
        tick();
        tick();
        rstn = 1'b1;

        // Reset state
        #1;
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_line_valid", line_valid, 1'b0);
        check("rst_line_data", line_data, '0);
        check("rst_line_paddr", line_paddr, '0);
        check("rst_beat_err", beat_err, 1'b0);

        // Basic refill, ack at cycle 3
        issue_miss(40'h80001234, 2'd2);
        #1;
        check("t1_req_valid", req_valid, 1'b1);
        check("t1_req_paddr", req_paddr, 40'h80001220);
        check("t1_req_way", req_way, 2'd2);
        check("t1_busy", busy, 1'b1);
        check("t1_ready", ready, 1'b0);
        tick();
        #1 check("t1_req_hold", req_valid, 1'b1);
        tick();
        do_ack();
        for (int i = 0; i < 4; i++) begin
            send_beat(2'(i), 64'hA + 64'(i), 1'b0, "t1_beat_err");
        end
        #1;
        check("t1_line_valid", line_valid, 1'b1);
        check("t1_line_data", line_data, LINE_ABCD);
        check("t1_line_way", line_way, 2'd2);
        check("t1_line_paddr", line_paddr, 40'h80001220);
        check("t1_ready_done", ready, 1'b0);
        tick();
        #1;
        check("t1_line_valid_pulse", line_valid, 1'b0);
        check("t1_ready_after", ready, 1'b1);
        check("t1_line_data_hold", line_data, LINE_ABCD);

        // Kill in REQ: request held until ack, beats drained, no line
        issue_miss(40'h001000007F, 2'd1);
        kill = 1'b1;
        #1 check("t2_req_valid", req_valid, 1'b1);
        tick();
        kill = 1'b0;
        #1 check("t2_req_held_after_kill", req_valid, 1'b1);
        check("t2_req_paddr", req_paddr, 40'h0010000060);
        do_ack();
        for (int i = 0; i < 4; i++) begin
            send_beat(2'(i), 64'h100 + 64'(i), 1'b0, "t2_beat_err");
        end
        #1;
        check("t2_line_valid", line_valid, 1'b0);
        check("t2_ready", ready, 1'b1);

        // Out-of-order beats 0,2,1,3
        issue_miss(40'h0020000000, 2'd3);
        do_ack();
        send_beat(2'd0, 64'h1, 1'b0, "t3_beat0_err");
        send_beat(2'd2, 64'h2, 1'b1, "t3_beat2_err");
        send_beat(2'd1, 64'h3, 1'b1, "t3_beat1_err");
        send_beat(2'd3, 64'h4, 1'b0, "t3_beat3_err");
        #1;
        check("t3_line_valid", line_valid, 1'b0);
        check("t3_ready", ready, 1'b1);

        // Miss with kill in IDLE is refused; stray beat in IDLE flagged
        miss_valid = 1'b1;
        kill       = 1'b1;
        miss_paddr = 40'h0030000000;
        #1 check("t4_ready", ready, 1'b1);
        tick();
        miss_valid = 1'b0;
        kill       = 1'b0;
        #1;
        check("t4_ready_after", ready, 1'b1);
        check("t4_req_valid", req_valid, 1'b0);
        send_beat(2'd0, 64'hFF, 1'b1, "t4_stray_err");
        #1;
        check("t4_err_pulse", beat_err, 1'b0);
        check("t4_still_idle", ready, 1'b1);

        // Kill on the last beat drops the line
        issue_miss(40'h0040000000, 2'd0);
        do_ack();
        for (int i = 0; i < 3; i++) begin
            send_beat(2'(i), 64'h5, 1'b0, "t5_beat_err");
        end
        kill = 1'b1;
        send_beat(2'd3, 64'h5, 1'b0, "t5_last_err");
        kill = 1'b0;
        #1;
        check("t5_line_valid", line_valid, 1'b0);
        check("t5_ready", ready, 1'b1);

        // Kill in DONE masks the line_valid pulse
        issue_miss(40'h0050000000, 2'd1);
        do_ack();
        for (int i = 0; i < 4; i++) begin
            send_beat(2'(i), 64'h6, 1'b0, "t6_beat_err");
        end
        kill = 1'b1;
        #1;
        check("t6_line_valid_killed", line_valid, 1'b0);
        check("t6_busy_done", busy, 1'b1);
        tick();
        kill = 1'b0;
        #1 check("t6_ready", ready, 1'b1);

        // Reset during WAIT_DATA after two beats
        issue_miss(40'h0012345678, 2'd1);
        do_ack();
        send_beat(2'd0, 64'h11, 1'b0, "t7_beat0_err");
        send_beat(2'd1, 64'h22, 1'b0, "t7_beat1_err");
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        check("t7_ready", ready, 1'b1);
        check("t7_busy", busy, 1'b0);
        check("t7_req_valid", req_valid, 1'b0);
        check("t7_line_data", line_data, '0);
        check("t7_line_paddr", line_paddr, '0);
        check("t7_line_way", line_way, '0);
        send_beat(2'd2, 64'h33, 1'b1, "t7_stray_err");

        // Minimum latency after reset: ack cycle 1, line_valid cycle 6
        issue_miss(40'h00ABCDEF1F, 2'd3);
        do_ack();
        send_beat(2'd0, 64'h1111111111111111, 1'b0, "t8_beat_err");
        send_beat(2'd1, 64'h2222222222222222, 1'b0, "t8_beat_err");
        send_beat(2'd2, 64'h3333333333333333, 1'b0, "t8_beat_err");
        send_beat(2'd3, 64'h4444444444444444, 1'b0, "t8_beat_err");
        #1;
        check("t8_line_valid", line_valid, 1'b1);
        check("t8_line_data", line_data, LINE_MIN);
        check("t8_line_paddr", line_paddr, 40'h00ABCDEF00);
        check("t8_line_way", line_way, 2'd3);

        // Single-beat instance: ack at cycle 1, line_valid at cycle 3
        tick();
        miss_valid_b = 1'b1;
        miss_paddr_b = 40'hFFFFFFFFFF;
        miss_way_b   = 2'd3;
        #1 check("b_ready", ready_b, 1'b1);
        tick();
        miss_valid_b = 1'b0;
        ack_b        = 1'b1;
        #1;
        check("b_req_valid", req_valid_b, 1'b1);
        check("b_req_paddr", req_paddr_b, 40'hFFFFFFFFE0);
        tick();
        ack_b        = 1'b0;
        resp_valid_b = 1'b1;
        resp_beat_b  = 1'b0;
        resp_data_b  = LINE_ONE;
        #1 check("b_beat_err", beat_err_b, 1'b0);
        tick();
        resp_valid_b = 1'b0;
        resp_data_b  = '0;
        #1;
        check("b_line_valid", line_valid_b, 1'b1);
        check("b_line_data", line_data_b, LINE_ONE);
        check("b_line_way", line_way_b, 2'd3);
        tick();
        #1;
        check("b_line_valid_pulse", line_valid_b, 1'b0);
        check("b_ready_after", ready_b, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_refill_unit.md
# sargantana_icache_refill_unit

Parametrised instruction-cache refill controller that sits between the icache control FSM and the IFILL port. Accepts one line-miss request, issues a line-aligned fill request to the memory side, and assembles a configurable number of response beats into a full cache line. Delivers the line with its target way for the data/tag array write, supporting kill/cancel and beat-order checking.

## Interface
- LINE_WIDTH, 256, cache line width in bits
- BEAT_WIDTH, 64, bits per IFILL response beat; LINE_WIDTH % BEAT_WIDTH == 0; NBEATS = LINE_WIDTH/BEAT_WIDTH, 1..16
- PADDR_SIZE, 40, physical address width
- N_WAY, 4, associativity; WAY_W = max(1, clog2(N_WAY))
- OFFSET_WIDTH, 5, line offset bits cleared in requests (= clog2(LINE_WIDTH/8))
- BEAT_W (derived) = max(1, clog2(NBEATS))

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rstn_i  in  1  reset, synchronous, active-low
- miss_valid_i  in  1  refill request from icache ctrl
- miss_paddr_i  in  PADDR_SIZE  miss physical address, any offset
- miss_way_i  in  WAY_W  victim way
- kill_i  in  1  cancel the in-flight refill
- ready_o  out  1  unit can accept a miss this cycle
- busy_o  out  1  refill in flight (not IDLE)
- ifill_req_valid_o  out  1  fill request valid
- ifill_req_paddr_o  out  PADDR_SIZE  line-aligned address
- ifill_req_way_o  out  WAY_W  way being replaced
- ifill_ack_i  in  1  request accepted by memory side
- ifill_resp_valid_i  in  1  response beat valid
- ifill_resp_beat_i  in  BEAT_W  beat index
- ifill_resp_data_i  in  BEAT_WIDTH  beat payload
- line_valid_o  out  1  one-cycle pulse: assembled line ready for array write
- line_data_o  out  LINE_WIDTH  assembled line, beat i at bits [i*BEAT_WIDTH +: BEAT_WIDTH]
- line_paddr_o  out  PADDR_SIZE  line-aligned address of delivered line
- line_way_o  out  WAY_W  target way
- beat_err_o  out  1  one-cycle pulse on protocol error

## Operation
- FSM states: IDLE, REQ, WAIT_DATA, DONE. A `killed` flag travels with the request.
- IDLE: ready_o=1. If miss_valid_i & !kill_i: latch paddr with bits [OFFSET_WIDTH-1:0] zeroed, latch way, clear beat counter and killed flag, go to REQ. If kill_i is high in the same cycle, kill wins and the miss is not accepted.
- REQ: ifill_req_valid_o=1, with paddr and way held stable until ack. On ifill_ack_i, go to WAIT_DATA. kill_i in REQ sets killed; the request stays asserted until acked, because a request cannot be retracted.
- WAIT_DATA: on each ifill_resp_valid_i, write data into slice `cnt` and increment cnt (NBEATS-bit wrap irrelevant).
  - ifill_resp_beat_i != cnt: beat_err_o pulses, killed is set, slice `cnt` is still written, and counting continues.
  - kill_i in WAIT_DATA sets killed. Remaining beats are still drained.
  - On the beat where cnt == NBEATS-1: go to DONE if !killed (including kill_i that same cycle), else go to IDLE.
- DONE: line_valid_o = !kill_i, then unconditionally go to IDLE. ready_o=0.
- ifill_resp_valid_i in IDLE, REQ or DONE: beat dropped, beat_err_o pulses, no state change.
- line_data_o, line_paddr_o, line_way_o are registers. They are stable from DONE until the next accepted miss. Stale data is permitted outside line_valid_o.
- busy_o = (state != IDLE). ready_o = (state == IDLE).

## Timing
- Reset (rstn_i low at clock edge): state IDLE, killed=0, cnt=0, all outputs 0 except ready_o=1; line_data_o, line_paddr_o, line_way_o cleared to 0. Reset mid-refill abandons the refill. Beats arriving afterwards are treated as stray and flag beat_err_o.
- Miss accepted at cycle 0 → ifill_req_valid_o high from cycle 1.
- Ack sampled at cycle a → first beat is accepted no earlier than cycle a+1.
- Last beat at cycle m → line_valid_o at cycle m+1 (single cycle) → ready_o at m+2.
- Minimum miss-to-line latency, with ack at cycle 1 and back-to-back beats: line_valid_o at cycle NBEATS+2.
- One request outstanding at a time. No bypass of beat data to line outputs.
- beat_err_o is registered-free: asserted in the same cycle as the offending ifill_resp_valid_i.

## Test plan
- Defaults (NBEATS=4): miss paddr 0x80001234, way 2, ack at cycle 3, beats 0..3 data 0xA..0xD back-to-back → req paddr 0x80001220, line_valid_o one cycle after beat 3, line_data_o = {0xD,0xC,0xB,0xA}, line_way_o=2, beat_err_o never high.
- kill_i pulsed in REQ, then ack and 4 beats → no line_valid_o, return to IDLE after beat 3, ready_o=1 next cycle, no beat_err_o.
- Beat order 0,2,1,3 → beat_err_o pulses with beat 2, line_valid_o never asserted, IDLE after fourth beat.
- miss_valid_i and kill_i high together in IDLE → ready_o stays 1, ifill_req_valid_o stays 0. Stray resp beat in IDLE → beat_err_o=1 for one cycle.
- rstn_i low during WAIT_DATA after 2 beats → next cycle all outputs at reset values. A new miss then completes normally with correct data.
- Parameters LINE_WIDTH=256, BEAT_WIDTH=256 (NBEATS=1): single beat index 0 → line_valid_o at cycle a+2 with full payload.
